// File: rtl/psram_ctrl_pkg.sv
// rtl/psram_ctrl_pkg.sv - shared types and constants for the async cellular RAM controller
package psram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RECOVER
    } state_t;

    // Field order matches the memory pin group {Adv, Clk, CS, OE, WR, LB, UB}
    typedef struct packed {
        logic adv;
        logic clk;
        logic cs;
        logic oe;
        logic wr;
        logic lb;
        logic ub;
    } ctrl_t;

    localparam ctrl_t CTRL_INACTIVE = 7'b101_1111;
    localparam int    MEM_ADDR_W    = 23;
    localparam int    MEM_DATA_W    = 16;

endpackage

// File: rtl/psram_ctrl_timer.sv
// rtl/psram_ctrl_timer.sv - loadable saturating down-counter timing the WAIT and TURN phases
module psram_ctrl_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loaded with N on phase entry, so a value of 1 marks the Nth clock of the phase
    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/psram_async_ctrl.sv
// rtl/psram_async_ctrl.sv - request/ready async-mode cellular RAM controller
// PSRAM_CTRL_BYTE_EN: when defined, RamLB/RamUB follow the latched byte enables.
module psram_async_ctrl
    import psram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 6,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [1:0]            be,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    inout  wire  [MEM_DATA_W-1:0] MemDB,
    output logic [MEM_ADDR_W-1:0] MemAdr,
    output logic                  RamAdv,
    output logic                  RamClk,
    output logic                  RamCS,
    output logic                  MemOE,
    output logic                  MemWR,
    output logic                  RamLB,
    output logic                  RamUB
);

    localparam int MAX_CYCLES = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    if (DATA_W != MEM_DATA_W) begin : g_bad_data_w
        $error("psram_async_ctrl: DATA_W must be 16");
    end
    if (ADDR_W < 1 || ADDR_W > MEM_ADDR_W) begin : g_bad_addr_w
        $error("psram_async_ctrl: ADDR_W must be 1..23");
    end
    if (WAIT_CYCLES < 2 || TURN_CYCLES < 1) begin : g_bad_timing
        $error("psram_async_ctrl: WAIT_CYCLES >= 2 and TURN_CYCLES >= 1 required");
    end

    state_t              state, state_next;
    ctrl_t               ctrl_q, ctrl_d;
    logic                drive_q, drive_d;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          lane_n;
    logic                accept;
    logic                phase_done;
    logic                timer_load;
    logic [CNT_W-1:0]    timer_val;

    assign accept = req && (state == ST_IDLE);

    psram_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (phase_done)
    );

    assign timer_load = (state_next != state);
    assign timer_val  = CNT_W'((state_next == ST_RECOVER) ? TURN_CYCLES : WAIT_CYCLES);

`ifdef PSRAM_CTRL_BYTE_EN
    logic [1:0] be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            be_q <= 2'b00;
        end else if (accept) begin
            be_q <= be;
        end
    end

    // Strobes are registered at the accept edge, so the raw request enables are used there
    assign lane_n = ~(accept ? be : be_q);
`else
    logic unused_be;
    assign unused_be = ^be;
    assign lane_n    = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctrl_q  <= CTRL_INACTIVE;
            drive_q <= 1'b0;
            wdata_q <= '0;
            MemAdr  <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
        end else begin
            state   <= state_next;
            ctrl_q  <= ctrl_d;
            drive_q <= drive_d;
            rvalid  <= (state == ST_READ) && phase_done;
            if ((state == ST_READ) && phase_done) begin
                rdata <= MemDB;
            end
            if (accept) begin
                wdata_q <= wdata;
                MemAdr  <= MEM_ADDR_W'(addr);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:           if (req) state_next = we ? ST_WRITE : ST_READ;
            ST_READ, ST_WRITE: if (phase_done) state_next = ST_RECOVER;
            ST_RECOVER:        if (phase_done) state_next = ST_IDLE;
            default:           state_next = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered
    always_comb begin
        ctrl_d  = CTRL_INACTIVE;
        drive_d = 1'b0;
        case (state_next)
            ST_READ: begin
                ctrl_d.adv = 1'b0;
                ctrl_d.cs  = 1'b0;
                ctrl_d.oe  = 1'b0;
                ctrl_d.lb  = lane_n[0];
                ctrl_d.ub  = lane_n[1];
            end
            ST_WRITE: begin
                ctrl_d.adv = 1'b0;
                ctrl_d.cs  = 1'b0;
                ctrl_d.wr  = 1'b0;
                ctrl_d.lb  = lane_n[0];
                ctrl_d.ub  = lane_n[1];
                drive_d    = 1'b1;
            end
            default: ;
        endcase
        if ((state == ST_WRITE) && (state_next == ST_RECOVER)) begin
            drive_d = 1'b1;
        end
    end

    assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_q;
    assign ready = (state == ST_IDLE);
    assign MemDB = drive_q ? wdata_q : {MEM_DATA_W{1'bz}};

endmodule
